// File: rtl/matvec_seq_ctrl_if.sv
// matvec_seq_ctrl_if: signal bundle between the matrix-path sequencer and its
// X-load source, A memory, 9-tap MAC ALU and result memory.
//   master modport : the sequencer (drives ready/enables/addresses/X regs)
//   slave modport  : the surrounding datapath (drives start, X words, ALU result)
// Signals:
//   start, reuse_x        job request and "keep current X" flag
//   x_valid/x_ready/x_data 24-bit X load handshake (MSB byte first)
//   a_ren, a_addr         A-memory read (data returns one cycle later)
//   alu_en, x_reg1..3     ALU enable and the 9 X bytes
//   alu_web, alu_sum      ALU write strobe and 20-bit result
//   res_we/addr/data      result-memory write port
//   busy, done            job status
interface matvec_seq_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              reuse_x;
    logic              x_valid;
    logic [23:0]       x_data;
    logic              x_ready;
    logic              a_ren;
    logic [ADDR_W-1:0] a_addr;
    logic              alu_en;
    logic [23:0]       x_reg1;
    logic [23:0]       x_reg2;
    logic [23:0]       x_reg3;
    logic              alu_web;
    logic [19:0]       alu_sum;
    logic              res_we;
    logic [ADDR_W-1:0] res_addr;
    logic [19:0]       res_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, reuse_x, x_valid, x_data, alu_web, alu_sum,
        output x_ready, a_ren, a_addr, alu_en, x_reg1, x_reg2, x_reg3,
        output res_we, res_addr, res_data, busy, done
    );

    modport slave (
        output start, reuse_x, x_valid, x_data, alu_web, alu_sum,
        input  x_ready, a_ren, a_addr, alu_en, x_reg1, x_reg2, x_reg3,
        input  res_we, res_addr, res_data, busy, done
    );
endinterface

// File: rtl/matvec_seq_ctrl.sv
// matvec_seq_ctrl: sequencer for the 9-tap multiply-accumulate ALU.
// Loads three 24-bit X words, streams ROWS A-memory reads back to back,
// aligns alu_en with the synchronous read data, and writes each ALU sum to
// the result memory at the row address delayed by two cycles. done pulses
// one cycle after the last result write.
// Ports:
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  matvec_seq_ctrl_if master modport (see interface header)
module matvec_seq_ctrl #(
    parameter int ROWS   = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    matvec_seq_ctrl_if.master   bus
);
    // One extra bit so ROWS = 2^ADDR_W is representable before the compare.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadX,
        StIssue,
        StDrain,
        StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        xcnt_q, xcnt_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  wr_q, wr_d;
    logic [23:0]       x1_q, x1_d;
    logic [23:0]       x2_q, x2_d;
    logic [23:0]       x3_q, x3_d;
    logic              alu_en_q;
    logic [ADDR_W-1:0] addr_p1_q, addr_p2_q;
    logic              a_ren;
    logic              x_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            xcnt_q    <= '0;
            row_q     <= '0;
            wr_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            x3_q      <= '0;
            alu_en_q  <= 1'b0;
            addr_p1_q <= '0;
            addr_p2_q <= '0;
        end else begin
            state_q   <= state_d;
            xcnt_q    <= xcnt_d;
            row_q     <= row_d;
            wr_q      <= wr_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            x3_q      <= x3_d;
            // Read data lands one cycle after a_ren; the ALU result one more.
            alu_en_q  <= a_ren;
            addr_p1_q <= bus.a_addr;
            addr_p2_q <= addr_p1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        xcnt_d  = xcnt_q;
        row_d   = row_q;
        wr_d    = wr_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        x_fire  = (state_q == StLoadX) && bus.x_valid;

        if (bus.res_we) begin
            wr_d = wr_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                row_d = '0;
                if (bus.start) begin
                    wr_d = '0;
                    if (bus.reuse_x) begin
                        state_d = StIssue;
                    end else begin
                        state_d = StLoadX;
                        xcnt_d  = '0;
                    end
                end
            end
            StLoadX: begin
                if (x_fire) begin
                    xcnt_d = xcnt_q + 1'b1;
                    case (xcnt_q)
                        2'd0:    x1_d = bus.x_data;
                        2'd1:    x2_d = bus.x_data;
                        default: begin
                            x3_d    = bus.x_data;
                            row_d   = '0;
                            state_d = StIssue;
                        end
                    endcase
                end
            end
            StIssue: begin
                row_d = row_q + 1'b1;
                if (row_q == LAST_ROW) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // This res_we is the ROWS-th write of the job.
                if (bus.res_we && (wr_q == LAST_ROW)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign a_ren        = (state_q == StIssue);
    assign bus.a_ren    = a_ren;
    assign bus.a_addr   = row_q[ADDR_W-1:0];
    assign bus.alu_en   = alu_en_q;
    assign bus.x_reg1   = x1_q;
    assign bus.x_reg2   = x2_q;
    assign bus.x_reg3   = x3_q;
    assign bus.x_ready  = (state_q == StLoadX);
    assign bus.res_we   = bus.alu_web;
    assign bus.res_addr = addr_p2_q;
    assign bus.res_data = bus.alu_sum;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StFinish);
endmodule

// File: tb/tb_matvec_seq_ctrl.sv
module tb_matvec_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matvec_seq_ctrl_if #(.ADDR_W(4)) bus0 ();
    matvec_seq_ctrl_if #(.ADDR_W(4)) bus1 ();

    matvec_seq_ctrl #(.ROWS(16), .ADDR_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    matvec_seq_ctrl #(.ROWS(1),  .ADDR_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // A memory + 9-tap MAC ALU models
    function automatic logic [19:0] mac9(input logic [71:0] a, input logic [71:0] x);
        logic [19:0] s;
        s = '0;
        for (int j = 0; j < 9; j++) s += 20'(a[8*j +: 8]) * 20'(x[8*j +: 8]);
        return s;
    endfunction

    logic [71:0] a_mem0 [16];
    logic [71:0] a_row1;
    logic [71:0] a_rdata0, a_rdata1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata0 <= '0;
            bus0.alu_web <= 1'b0;
            bus0.alu_sum <= '0;
        end else begin
            if (bus0.a_ren) a_rdata0 <= a_mem0[bus0.a_addr];
            bus0.alu_web <= bus0.alu_en;
            bus0.alu_sum <= bus0.alu_en ?
                mac9(a_rdata0, {bus0.x_reg1, bus0.x_reg2, bus0.x_reg3}) : 20'd0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata1 <= '0;
            bus1.alu_web <= 1'b0;
            bus1.alu_sum <= '0;
        end else begin
            if (bus1.a_ren) a_rdata1 <= a_row1;
            bus1.alu_web <= bus1.alu_en;
            bus1.alu_sum <= bus1.alu_en ?
                mac9(a_rdata1, {bus1.x_reg1, bus1.x_reg2, bus1.x_reg3}) : 20'd0;
        end
    end

    // Event monitors (sampled on the falling edge)
    int   ren_cnt0 = 0, we_cnt0 = 0, done_cnt0 = 0;
    int   ren_rise0 = 0, last_we0 = 0, done_cyc0 = 0;
    logic ren_prev0 = 1'b0;
    logic [3:0]  log_addr0 [256];
    logic [19:0] log_data0 [256];

    always @(negedge clk) begin
        ren_prev0 <= bus0.a_ren;
        if (bus0.a_ren && !ren_prev0) ren_rise0 <= cyc;
        if (bus0.a_ren) ren_cnt0 <= ren_cnt0 + 1;
        if (bus0.res_we) begin
            log_addr0[we_cnt0] <= bus0.res_addr;
            log_data0[we_cnt0] <= bus0.res_data;
            we_cnt0  <= we_cnt0 + 1;
            last_we0 <= cyc;
        end
        if (bus0.done) begin
            done_cnt0 <= done_cnt0 + 1;
            done_cyc0 <= cyc;
        end
    end

    int   ren_cnt1 = 0, en_cnt1 = 0, we_cnt1 = 0, done_cnt1 = 0;
    int   ren_rise1 = 0, last_we1 = 0, done_cyc1 = 0;
    logic ren_prev1 = 1'b0;
    logic [3:0]  last_addr1 = '0;
    logic [19:0] last_data1 = '0;

    always @(negedge clk) begin
        ren_prev1 <= bus1.a_ren;
        if (bus1.a_ren && !ren_prev1) ren_rise1 <= cyc;
        if (bus1.a_ren) ren_cnt1 <= ren_cnt1 + 1;
        if (bus1.alu_en) en_cnt1 <= en_cnt1 + 1;
        if (bus1.res_we) begin
            last_addr1 <= bus1.res_addr;
            last_data1 <= bus1.res_data;
            we_cnt1    <= we_cnt1 + 1;
            last_we1   <= cyc;
        end
        if (bus1.done) begin
            done_cnt1 <= done_cnt1 + 1;
            done_cyc1 <= cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int b_we, b_done, b_ren;

    task automatic snap0();
        b_we   = we_cnt0;
        b_done = done_cnt0;
        b_ren  = ren_cnt0;
    endtask

    task automatic load_x0(input logic [23:0] w1, input logic [23:0] w2, input logic [23:0] w3);
        bus0.start   = 1'b1;
        bus0.reuse_x = 1'b0;
        tick();
        bus0.start   = 1'b0;
        bus0.x_valid = 1'b1;
        bus0.x_data  = w1;
        tick();
        bus0.x_data  = w2;
        tick();
        bus0.x_data  = w3;
        tick();
        bus0.x_valid = 1'b0;
    endtask

    task automatic wait_end0(input string tag);
        for (int i = 0; i < 100 && bus0.busy; i++) tick();
        check_val(tag, 32'(bus0.busy), 0);
        tick();
    endtask

    // Expected data for row r is cst + step*r
    task automatic check_job0(input string tag, input int cst, input int step);
        check_val({tag, "_nwe"},   32'(we_cnt0 - b_we), 16);
        check_val({tag, "_nren"},  32'(ren_cnt0 - b_ren), 16);
        check_val({tag, "_ndone"}, 32'(done_cnt0 - b_done), 1);
        check_val({tag, "_we_lat"},   32'(last_we0 - ren_rise0), 17);
        check_val({tag, "_done_lat"}, 32'(done_cyc0 - last_we0), 1);
        for (int r = 0; r < 16; r++) begin
            check_val($sformatf("%s_addr%0d", tag, r), 32'(log_addr0[b_we + r]), 32'(r));
            check_val($sformatf("%s_data%0d", tag, r), 32'(log_data0[b_we + r]),
                      32'(cst + step * r));
        end
    endtask

    int          vpat [6] = '{1, 0, 0, 1, 0, 1};
    logic [23:0] words [3] = '{24'h0a0b0c, 24'h0d0e0f, 24'h101112};

    initial begin
        bus0.start = 1'b0; bus0.reuse_x = 1'b0; bus0.x_valid = 1'b0; bus0.x_data = '0;
        bus1.start = 1'b0; bus1.reuse_x = 1'b0; bus1.x_valid = 1'b0; bus1.x_data = '0;
        for (int r = 0; r < 16; r++) a_mem0[r] = {9{8'h01}};
        a_row1 = {9{8'h02}};
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_val("rst_busy",   32'(bus0.busy), 0);
        check_val("rst_done",   32'(bus0.done), 0);
        check_val("rst_a_ren",  32'(bus0.a_ren), 0);
        check_val("rst_alu_en", 32'(bus0.alu_en), 0);
        check_val("rst_res_we", 32'(bus0.res_we), 0);
        check_val("rst_x_ready", 32'(bus0.x_ready), 0);
        check_val("rst_a_addr", 32'(bus0.a_addr), 0);
        check_val("rst_res_addr", 32'(bus0.res_addr), 0);
        check_val("rst_x_reg1", 32'(bus0.x_reg1), 0);

        // 1: full job with X load
        snap0();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        check_val("t1_x_ready", 32'(bus0.x_ready), 1);
        check_val("t1_busy",    32'(bus0.busy), 1);
        bus0.x_valid = 1'b1;
        bus0.x_data  = 24'h010203; tick();
        bus0.x_data  = 24'h040506; tick();
        check_val("t1_no_ren", 32'(bus0.a_ren), 0);
        bus0.x_data  = 24'h070809; tick();
        bus0.x_valid = 1'b0;
        check_val("t1_ren", 32'(bus0.a_ren), 1);
        check_val("t1_x_reg1", 32'(bus0.x_reg1), 32'h010203);
        check_val("t1_x_reg2", 32'(bus0.x_reg2), 32'h040506);
        check_val("t1_x_reg3", 32'(bus0.x_reg3), 32'h070809);
        wait_end0("t1_end");
        check_job0("t1", 45, 0);

        // 2: stalled X load
        snap0();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        begin
            int k;
            k = 0;
            for (int i = 0; i < 6; i++) begin
                check_val($sformatf("t2_no_ren%0d", i), 32'(bus0.a_ren), 0);
                bus0.x_valid = (vpat[i] != 0);
                if (vpat[i] != 0) begin
                    bus0.x_data = words[k];
                    k++;
                end else begin
                    bus0.x_data = 24'hdead00 | 24'(i);
                end
                tick();
            end
        end
        bus0.x_valid = 1'b0;
        check_val("t2_ren", 32'(bus0.a_ren), 1);
        check_val("t2_x_reg1", 32'(bus0.x_reg1), 32'h0a0b0c);
        check_val("t2_x_reg2", 32'(bus0.x_reg2), 32'h0d0e0f);
        check_val("t2_x_reg3", 32'(bus0.x_reg3), 32'h101112);
        wait_end0("t2_end");
        check_job0("t2", 126, 0);

        // 3: reuse X with garbage on the load port
        snap0();
        bus0.start   = 1'b1;
        bus0.reuse_x = 1'b1;
        bus0.x_valid = 1'b1;
        bus0.x_data  = 24'hffffff;
        tick();
        bus0.start   = 1'b0;
        bus0.reuse_x = 1'b0;
        check_val("t3_x_ready", 32'(bus0.x_ready), 0);
        check_val("t3_ren",     32'(bus0.a_ren), 1);
        wait_end0("t3_end");
        bus0.x_valid = 1'b0;
        check_val("t3_x_reg1", 32'(bus0.x_reg1), 32'h0a0b0c);
        check_val("t3_x_reg2", 32'(bus0.x_reg2), 32'h0d0e0f);
        check_val("t3_x_reg3", 32'(bus0.x_reg3), 32'h101112);
        check_job0("t3", 126, 0);

        // 4: row r = all bytes r, X = all ones
        for (int r = 0; r < 16; r++) a_mem0[r] = {9{8'(r)}};
        snap0();
        load_x0(24'h010101, 24'h010101, 24'h010101);
        wait_end0("t4_end");
        check_job0("t4", 0, 9);

        // 5: ROWS=1 instance, start pulses while busy
        begin
            int w1, r1, e1, d1;
            w1 = we_cnt1; r1 = ren_cnt1; e1 = en_cnt1; d1 = done_cnt1;
            bus1.start = 1'b1;
            tick();
            bus1.x_valid = 1'b1;
            bus1.x_data  = 24'h010101;
            tick();
            bus1.start = 1'b0;
            tick();
            tick();
            bus1.x_valid = 1'b0;
            check_val("t5_ren", 32'(bus1.a_ren), 1);
            tick();
            bus1.start = 1'b1;
            tick();
            bus1.start = 1'b0;
            for (int i = 0; i < 20 && bus1.busy; i++) tick();
            check_val("t5_end", 32'(bus1.busy), 0);
            repeat (5) tick();
            check_val("t5_idle",  32'(bus1.busy), 0);
            check_val("t5_nren",  32'(ren_cnt1 - r1), 1);
            check_val("t5_nen",   32'(en_cnt1 - e1), 1);
            check_val("t5_nwe",   32'(we_cnt1 - w1), 1);
            check_val("t5_ndone", 32'(done_cnt1 - d1), 1);
            check_val("t5_addr",  32'(last_addr1), 0);
            check_val("t5_data",  32'(last_data1), 18);
            check_val("t5_we_lat",   32'(last_we1 - ren_rise1), 2);
            check_val("t5_done_lat", 32'(done_cyc1 - last_we1), 1);
        end

        // 6: reset while issuing row 5
        bus0.start   = 1'b1;
        bus0.reuse_x = 1'b1;
        tick();
        bus0.start   = 1'b0;
        bus0.reuse_x = 1'b0;
        for (int i = 0; i < 40 && !(bus0.a_ren && bus0.a_addr == 4'd5); i++) tick();
        check_val("t6_row5", 32'(bus0.a_addr), 5);
        rst = 1'b1;
        #1;
        check_val("t6_busy",   32'(bus0.busy), 0);
        check_val("t6_a_ren",  32'(bus0.a_ren), 0);
        check_val("t6_alu_en", 32'(bus0.alu_en), 0);
        check_val("t6_res_we", 32'(bus0.res_we), 0);
        check_val("t6_res_data", 32'(bus0.res_data), 0);
        check_val("t6_a_addr", 32'(bus0.a_addr), 0);
        check_val("t6_res_addr", 32'(bus0.res_addr), 0);
        check_val("t6_x_reg1", 32'(bus0.x_reg1), 0);
        check_val("t6_x_reg2", 32'(bus0.x_reg2), 0);
        check_val("t6_x_reg3", 32'(bus0.x_reg3), 0);
        b_we = we_cnt0;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check_val("t6_no_we", 32'(we_cnt0 - b_we), 0);
        check_val("t6_idle",  32'(bus0.busy), 0);
        snap0();
        load_x0(24'h010101, 24'h010101, 24'h010101);
        wait_end0("t6_end");
        check_job0("t6", 0, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
